test_status_monitor: RTL and testbench

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

---
 rtl/test_status_pkg.sv | 19 +
 rtl/tsm_hart_slot.sv | 45 ++++
 rtl/test_status_monitor.sv | 167 ++++++++++++++++
 tb/tb_test_status_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_pkg.sv
// Shared types and constants for the test status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_status_pkg;

   typedef enum logic [1:0] {
      TSM_IDLE    = 2'd0,
      TSM_RUN     = 2'd1,
      TSM_DONE    = 2'd2,
      TSM_TIMEOUT = 2'd3
   } tsm_state_e;

   // Exit codes follow the C convention; cast to CODE_W at the point of use.
   // EXIT_ERROR is signed -1 so a size cast sign-extends it to all-ones.
   localparam int EXIT_SUCCESS = 0;
   localparam int EXIT_FAIL    = 1;
   localparam int EXIT_ERROR   = -1;

endpackage

// File: rtl/tsm_hart_slot.sv
// Per-hart status slot: sticky done flag plus exit-code register with write gating.
// Latency: 1 cycle from hart_done/wr to done_flag/code.
// Backpressure: none; writes after the done flag is set are silently dropped.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - synchronous clear (monitor leaving the enabled state)
//   run         - monitor is in RUN; flag and code only update while high
//   hart_done   - end-of-computation level from the hart
//   wr, wr_code - exit-code write targeted at this slot
//   done_flag   - sticky done flag
//   code        - captured exit code, all-ones until written
module tsm_hart_slot
   import test_status_pkg::*;
#(
   parameter int CODE_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              run,
   input  logic              hart_done,
   input  logic              wr,
   input  logic [CODE_W-1:0] wr_code,
   output logic              done_flag,
   output logic [CODE_W-1:0] code
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         done_flag <= 1'b0;
         code      <= CODE_W'(EXIT_ERROR);
      end else if (run) begin
         // Gate on the registered flag: a write landing in the same cycle
         // as done is still taken, anything after that is frozen out.
         if (wr && !done_flag) begin
            code <= wr_code;
         end
         if (hart_done) begin
            done_flag <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/test_status_monitor.sv
// Test status monitor: collects per-hart done/exit-code reports and produces a pass/fail/timeout verdict.
// Latency: verdict registered one cycle after the done mask goes all-ones; timeout on the RUN cycle the counter reaches the limit.
// Backpressure: none; inputs are sampled every cycle, out-of-range writes are dropped and flagged.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   enable_i              - run enable; low returns to IDLE and clears all state
//   done_i                - per-hart end-of-computation levels
//   code_valid_i/hart/code- exit-code write strobe, target hart, value
//   timeout_i             - cycle limit for RUN, 0 disables
//   finished_o            - DONE or TIMEOUT reached
//   pass_o/fail_o/timeout_o, exit_code_o - terminal verdict
//   done_mask_o, cycles_o, bad_idx_o     - progress/status observability
module test_status_monitor
   import test_status_pkg::*;
#(
   parameter int NUM_HARTS = 3,
   parameter int CODE_W    = 32,
   parameter int CNT_W     = 32,
   localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic [NUM_HARTS-1:0] done_i,
   input  logic                 code_valid_i,
   input  logic [HART_W-1:0]    code_hart_i,
   input  logic [CODE_W-1:0]    code_i,
   input  logic [CNT_W-1:0]     timeout_i,
   output logic                 finished_o,
   output logic                 pass_o,
   output logic                 fail_o,
   output logic                 timeout_o,
   output logic [CODE_W-1:0]    exit_code_o,
   output logic [NUM_HARTS-1:0] done_mask_o,
   output logic [CNT_W-1:0]     cycles_o,
   output logic                 bad_idx_o
);

   tsm_state_e state_q, state_nxt;
   logic       run;

   logic [NUM_HARTS-1:0][CODE_W-1:0] slot_code;
   logic [CNT_W-1:0]                 cyc_inc;
   logic                             all_done;
   logic                             tmo_hit;
   logic                             idx_oob;
   logic                             any_nz;
   logic [CODE_W-1:0]                first_nz;
   logic                             verdict_pass;
   logic [CODE_W-1:0]                verdict_code;

   // ---------------------------------------------------------------- slots
   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
      tsm_hart_slot #(
         .CODE_W (CODE_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (!enable_i),
         .run       (run),
         .hart_done (done_i[h]),
         .wr        (code_valid_i && (code_hart_i == HART_W'(h))),
         .wr_code   (code_i),
         .done_flag (done_mask_o[h]),
         .code      (slot_code[h])
      );
   end

   // ---------------------------------------------------------- aggregation
   assign all_done = &done_mask_o;
   assign idx_oob  = 32'(code_hart_i) >= 32'(NUM_HARTS);
   assign cyc_inc  = (&cycles_o) ? cycles_o : cycles_o + 1'b1;
   // Compare against the post-increment count so TIMEOUT is entered with
   // cycles_o equal to the limit; >= lets a lowered limit fire at once.
   assign tmo_hit  = (timeout_i != '0) && (cyc_inc >= timeout_i);

   // Walk from the top so the lowest-index nonzero slot wins.
   always_comb begin
      any_nz   = 1'b0;
      first_nz = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (slot_code[h] != '0) begin
            any_nz   = 1'b1;
            first_nz = slot_code[h];
         end
      end
   end

   always_comb begin
      verdict_pass = !any_nz && !bad_idx_o;
      if (any_nz) begin
         verdict_code = first_nz;
      end else if (bad_idx_o) begin
         verdict_code = CODE_W'(EXIT_FAIL);
      end else begin
         verdict_code = CODE_W'(EXIT_SUCCESS);
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= TSM_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         TSM_IDLE: if (enable_i) state_nxt = TSM_RUN;
         TSM_RUN: begin
            // A completed mask beats a coincident timeout.
            if (all_done) begin
               state_nxt = TSM_DONE;
            end else if (tmo_hit) begin
               state_nxt = TSM_TIMEOUT;
            end
         end
         default: state_nxt = state_q;
      endcase
      if (!enable_i) begin
         state_nxt = TSM_IDLE;
      end
   end

   always_comb begin
      run        = (state_q == TSM_RUN);
      finished_o = (state_q == TSM_DONE) || (state_q == TSM_TIMEOUT);
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n || !enable_i) begin
         cycles_o  <= '0;
         bad_idx_o <= 1'b0;
      end else if (run) begin
         cycles_o <= cyc_inc;
         if (code_valid_i && idx_oob) begin
            bad_idx_o <= 1'b1;
         end
      end
   end

   // Verdict registers load on the same edge the FSM leaves RUN and then
   // hold, so they stay zero everywhere except DONE/TIMEOUT.
   always_ff @(posedge clk) begin
      if (!rst_n || !enable_i) begin
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         timeout_o   <= 1'b0;
         exit_code_o <= '0;
      end else if (run) begin
         if (all_done) begin
            pass_o      <= verdict_pass;
            fail_o      <= !verdict_pass;
            exit_code_o <= verdict_code;
         end else if (tmo_hit) begin
            timeout_o   <= 1'b1;
            exit_code_o <= CODE_W'(EXIT_ERROR);
         end
      end
   end

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [2:0]  done;
   logic        code_valid;
   logic [1:0]  code_hart;
   logic [31:0] code;
   logic [31:0] timeout;
   logic        finished_o, pass_o, fail_o, timeout_o, bad_idx_o;
   logic [31:0] exit_code_o, cycles_o;
   logic [2:0]  done_mask_o;

   always #5 clk = ~clk;

   test_status_monitor #(
      .NUM_HARTS (3),
      .CODE_W    (32),
      .CNT_W     (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (enable),
      .done_i       (done),
      .code_valid_i (code_valid),
      .code_hart_i  (code_hart),
      .code_i       (code),
      .timeout_i    (timeout),
      .finished_o   (finished_o),
      .pass_o       (pass_o),
      .fail_o       (fail_o),
      .timeout_o    (timeout_o),
      .exit_code_o  (exit_code_o),
      .done_mask_o  (done_mask_o),
      .cycles_o     (cycles_o),
      .bad_idx_o    (bad_idx_o)
   );

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        tmo;
      logic [31:0] exit;
      logic [31:0] cyc;
      logic        bad;
      logic [2:0]  mask;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    total = 0;
   int    n_bad = 0;
   logic  fin_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: one verdict per rising edge of finished_o.
   always @(negedge clk) begin
      if (finished_o && !fin_prev) begin
         if (sb_q.size() == 0) begin
            total++;
            n_bad++;
            $display("FAIL unexpected_finish: got verdict with no expected entry");
         end else begin
            exp_t  e;
            string n;
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            chk({n, ".pass"},  {31'd0, pass_o},      {31'd0, e.pass});
            chk({n, ".fail"},  {31'd0, fail_o},      {31'd0, e.fail});
            chk({n, ".tmo"},   {31'd0, timeout_o},   {31'd0, e.tmo});
            chk({n, ".exit"},  exit_code_o,          e.exit);
            chk({n, ".cyc"},   cycles_o,             e.cyc);
            chk({n, ".bad"},   {31'd0, bad_idx_o},   {31'd0, e.bad});
            chk({n, ".mask"},  {29'd0, done_mask_o}, {29'd0, e.mask});
         end
      end
      fin_prev = finished_o;
   end

   task automatic push(input string nm, input logic p, input logic f, input logic t,
                       input logic [31:0] ex, input logic [31:0] cy, input logic b,
                       input logic [2:0] m);
      exp_t e;
      e = '{pass: p, fail: f, tmo: t, exit: ex, cyc: cy, bad: b, mask: m};
      sb_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] h, input logic [31:0] c);
      code_valid = 1'b1;
      code_hart  = h;
      code       = c;
      step();
      code_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [2:0] m);
      done = m;
      step();
      done = 3'b000;
   endtask

   task automatic check_idle(input string nm);
      chk({nm, ".fin"},  {31'd0, finished_o},  32'd0);
      chk({nm, ".pass"}, {31'd0, pass_o},      32'd0);
      chk({nm, ".fail"}, {31'd0, fail_o},      32'd0);
      chk({nm, ".tmo"},  {31'd0, timeout_o},   32'd0);
      chk({nm, ".exit"}, exit_code_o,          32'd0);
      chk({nm, ".mask"}, {29'd0, done_mask_o}, 32'd0);
      chk({nm, ".cyc"},  cycles_o,             32'd0);
      chk({nm, ".bad"},  {31'd0, bad_idx_o},   32'd0);
   endtask

   // Drop enable for one cycle (clear), then enable; returns in RUN with cycles_o=0.
   task automatic begin_run(input string nm);
      enable = 1'b0;
      step();
      check_idle({nm, ".idle"});
      enable = 1'b1;
      step();
   endtask

   task automatic wait_fin(input string nm);
      int n = 0;
      while (!finished_o && n < 300) begin
         step();
         n++;
      end
      chk({nm, ".finished"}, {31'd0, finished_o}, 32'd1);
      step();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; done = 3'b000; code_valid = 1'b0;
      code_hart = 2'd0; code = 32'd0; timeout = 32'd0;
      repeat (3) step();
      check_idle("reset");
      rst_n = 1'b1;

      // All harts report 0 -> pass; DONE one cycle after mask completes.
      timeout = 32'd0;
      begin_run("t1");
      wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd0);
      chk("t1.run_cyc", cycles_o, 32'd3);
      chk("t1.run_exit", exit_code_o, 32'd0);
      push("t1", 1'b1, 1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 3'b111);
      pulse_done(3'b111);
      chk("t1.mask_set", {29'd0, done_mask_o}, 32'd7);
      chk("t1.not_yet", {31'd0, finished_o}, 32'd0);
      wait_fin("t1");

      // Last write before done wins; lowest nonzero slot reported.
      begin_run("t2");
      wr(2'd0, 32'd0); wr(2'd1, 32'd9); wr(2'd1, 32'd5); wr(2'd2, 32'd7);
      push("t2", 1'b0, 1'b1, 1'b0, 32'd5, 32'd6, 1'b0, 3'b111);
      pulse_done(3'b111);
      wait_fin("t2");

      // Write coinciding with done is captured, a later one is ignored.
      begin_run("t2b");
      wr(2'd0, 32'd0); wr(2'd1, 32'd0);
      code_valid = 1'b1; code_hart = 2'd2; code = 32'd7; done = 3'b100;
      step();
      code_valid = 1'b0; done = 3'b000;
      wr(2'd2, 32'd0);
      push("t2b", 1'b0, 1'b1, 1'b0, 32'd7, 32'd6, 1'b0, 3'b111);
      pulse_done(3'b011);
      wait_fin("t2b");

      // Hart2 never finishes -> timeout at cycles_o=100.
      timeout = 32'd100;
      begin_run("t3");
      wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd0);
      push("t3", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd100, 1'b0, 3'b011);
      pulse_done(3'b011);
      wait_fin("t3");

      // Completed mask and timeout in the same cycle -> DONE wins.
      timeout = 32'd0;
      begin_run("t4");
      wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd0);
      push("t4", 1'b1, 1'b0, 1'b0, 32'd0, 32'd5, 1'b0, 3'b111);
      pulse_done(3'b111);
      timeout = 32'd1;
      wait_fin("t4");

      // Lowering the limit below the current count fires on the next edge.
      timeout = 32'd0;
      begin_run("t4b");
      repeat (10) step();
      push("t4b", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd11, 1'b0, 3'b000);
      timeout = 32'd3;
      wait_fin("t4b");

      // Out-of-range hart index -> bad_idx, fail with EXIT_FAIL.
      timeout = 32'd0;
      begin_run("t5");
      wr(2'd3, 32'h55);
      chk("t5.bad_sticky", {31'd0, bad_idx_o}, 32'd1);
      wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd0);
      push("t5", 1'b0, 1'b1, 1'b0, 32'd1, 32'd6, 1'b1, 3'b111);
      pulse_done(3'b111);
      wait_fin("t5");

      // Reset mid-RUN discards codes; next run without writes fails.
      begin_run("t6");
      wr(2'd0, 32'd0); wr(2'd1, 32'd0); wr(2'd2, 32'd0);
      pulse_done(3'b001);
      rst_n = 1'b0;
      step();
      check_idle("t6.rst");
      rst_n = 1'b1;
      begin_run("t6r");
      push("t6", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'b111);
      pulse_done(3'b111);
      wait_fin("t6");

      repeat (3) step();
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, n_bad);
      $finish;
   end

endmodule
